// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit.
// Contents: access size and FSM state enums, fault codes, geometry constants,
// and size_bytes(), which maps an access size to its byte count.
package lsu_pkg;

    localparam int DATA_W    = 64;
    localparam int OFFSET_W  = 9;
    localparam int MEM_BYTES = 88;

    typedef enum logic [1:0] {
        WORD   = 2'b00,
        HALF   = 2'b01,
        BYTE   = 2'b10,
        DOUBLE = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACCESS  = 2'b01,
        CAPTURE = 2'b10,
        RESP    = 2'b11
    } state_e;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    function automatic logic [3:0] size_bytes(input size_e size);
        logic [3:0] n;
        case (size)
            BYTE:    n = 4'd1;
            HALF:    n = 4'd2;
            WORD:    n = 4'd4;
            DOUBLE:  n = 4'd8;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bundle of the pipeline request/response handshake and the data-memory bus.
// slave  : the load/store unit (accepts requests, drives responses and memory strobes)
// master : the pipeline plus memory side (drives requests, resp_ready and mem_rdata)
interface load_store_unit_if;
    import lsu_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic                req_is_store;
    size_e               req_size;
    logic                req_signed;
    logic [DATA_W-1:0]   req_base;
    logic [OFFSET_W-1:0] req_offset;
    logic [DATA_W-1:0]   req_wdata;

    logic                resp_valid;
    logic                resp_ready;
    logic [DATA_W-1:0]   resp_data;
    logic                resp_fault;
    logic [1:0]          resp_fault_code;

    logic                mem_write;
    logic                mem_read;
    size_e               mem_size_select;
    logic [DATA_W-1:0]   mem_address;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;

    modport slave (
        input  req_valid, req_is_store, req_size, req_signed, req_base, req_offset, req_wdata,
        output req_ready,
        output resp_valid, resp_data, resp_fault, resp_fault_code,
        input  resp_ready,
        output mem_write, mem_read, mem_size_select, mem_address, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_is_store, req_size, req_signed, req_base, req_offset, req_wdata,
        input  req_ready,
        input  resp_valid, resp_data, resp_fault, resp_fault_code,
        output resp_ready,
        input  mem_write, mem_read, mem_size_select, mem_address, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/load_store_unit_load_extend.sv
// Combinational size mask and extension.
// Ports: size (access size), is_signed (sign-extend from the top bit of the
// selected size), raw (input data), ext (masked/extended result).
// With is_signed = 0 it doubles as the store-data masker.
module load_extend
    import lsu_pkg::*;
(
    input  size_e             size,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] ext
);

    // Select the low bytes for the size and fill the upper bits.
    always_comb begin
        ext = '0;
        case (size)
            BYTE:    ext = {{56{is_signed & raw[7]}},  raw[7:0]};
            HALF:    ext = {{48{is_signed & raw[15]}}, raw[15:0]};
            WORD:    ext = {{32{is_signed & raw[31]}}, raw[31:0]};
            DOUBLE:  ext = raw;
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, computes base + sext(offset),
// checks alignment and bounds, performs a single memory access, and returns
// the extended load data or a fault code.
// Ports: clk (rising edge), reset (synchronous, active high),
//        bus (load_store_unit_if.slave: request, response and memory bus).
module load_store_unit
    import lsu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);

    state_e            state_r;
    state_e            state_next_s;
    logic              is_store_r;
    logic              signed_r;
    size_e             size_r;
    logic [DATA_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] resp_data_r;
    logic [1:0]        fault_code_r;

    logic [DATA_W-1:0] ea_s;
    logic [DATA_W:0]   ea_end_s;
    logic              misalign_s;
    logic              range_s;
    logic [1:0]        fault_s;
    logic [DATA_W-1:0] wdata_mask_s;
    logic [DATA_W-1:0] load_ext_s;
    logic              resp_valid_s;

    // Effective address and legality of the request currently presented.
    always_comb begin
        ea_s = bus.req_base
             + {{(DATA_W-OFFSET_W){bus.req_offset[OFFSET_W-1]}}, bus.req_offset};
        // One extra bit so an address near 2^64 cannot wrap back into range.
        ea_end_s = {1'b0, ea_s} + {61'b0, size_bytes(bus.req_size)};
        case (bus.req_size)
            BYTE:    misalign_s = 1'b0;
            HALF:    misalign_s = ea_s[0];
            WORD:    misalign_s = |ea_s[1:0];
            DOUBLE:  misalign_s = |ea_s[2:0];
            default: misalign_s = 1'b0;
        endcase
        range_s = (ea_end_s > 65'(MEM_BYTES));
        if (misalign_s) begin
            fault_s = FAULT_MISALIGN;
        end else if (range_s) begin
            fault_s = FAULT_RANGE;
        end else begin
            fault_s = FAULT_NONE;
        end
    end

    load_extend u_wdata_mask (
        .size      (bus.req_size),
        .is_signed (1'b0),
        .raw       (bus.req_wdata),
        .ext       (wdata_mask_s)
    );

    load_extend u_load_ext (
        .size      (size_r),
        .is_signed (signed_r),
        .raw       (bus.mem_rdata),
        .ext       (load_ext_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    state_next_s = (fault_s != FAULT_NONE) ? RESP : ACCESS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS:  state_next_s = is_store_r ? RESP : CAPTURE;
            CAPTURE: state_next_s = RESP;
            RESP: begin
                if (bus.resp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Request capture at accept and load-data capture one cycle after the read strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            is_store_r   <= 1'b0;
            signed_r     <= 1'b0;
            size_r       <= WORD;
            addr_r       <= '0;
            wdata_r      <= '0;
            resp_data_r  <= '0;
            fault_code_r <= FAULT_NONE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        is_store_r   <= bus.req_is_store;
                        signed_r     <= bus.req_signed;
                        size_r       <= bus.req_size;
                        addr_r       <= ea_s;
                        wdata_r      <= wdata_mask_s;
                        resp_data_r  <= '0;
                        fault_code_r <= fault_s;
                    end
                end
                CAPTURE: resp_data_r <= load_ext_s;
                default: ;
            endcase
        end
    end

    assign resp_valid_s        = (state_r == RESP);
    assign bus.req_ready       = (state_r == IDLE);
    assign bus.resp_valid      = resp_valid_s;
    assign bus.resp_data       = resp_valid_s ? resp_data_r : '0;
    assign bus.resp_fault_code = resp_valid_s ? fault_code_r : FAULT_NONE;
    assign bus.resp_fault      = resp_valid_s && (fault_code_r != FAULT_NONE);

    // Strobes are gated by reset directly so nothing commits while reset is high.
    assign bus.mem_write       = (state_r == ACCESS) &&  is_store_r && !reset;
    assign bus.mem_read        = (state_r == ACCESS) && !is_store_r && !reset;
    assign bus.mem_size_select = size_r;
    assign bus.mem_address     = addr_r;
    assign bus.mem_wdata       = wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a byte-array memory model answers
// the memory bus, and a separate reference memory plus rule-level arithmetic
// predicts every response, latency and strobe.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    byte unsigned mem     [MEM_BYTES];
    byte unsigned ref_mem [MEM_BYTES];
    int checks = 0;
    int fails  = 0;
    logic [63:0] last_resp;
    logic [63:0] last_exp;
    logic [63:0] rd_tmp;
    longint unsigned mem_a;

    function automatic int tb_nbytes(input logic [1:0] s);
        case (s)
            2'b00:   return 4;
            2'b01:   return 2;
            2'b10:   return 1;
            default: return 8;
        endcase
    endfunction

    // Data memory: writes commit at the edge, read data appears the cycle after mem_read.
    always @(posedge clk) begin
        mem_a = bus.mem_address;
        if (bus.mem_write) begin
            for (int i = 0; i < 8; i++) begin
                if (i < tb_nbytes(bus.mem_size_select) && mem_a < 64'(MEM_BYTES - i))
                    mem[int'(mem_a) + i] <= bus.mem_wdata[8*i +: 8];
            end
        end
        if (bus.mem_read) begin
            for (int i = 0; i < 8; i++) begin
                if (mem_a < 64'(MEM_BYTES - i)) rd_tmp[8*i +: 8] = mem[int'(mem_a) + i];
                else                            rd_tmp[8*i +: 8] = 8'h00;
            end
            bus.mem_rdata <= rd_tmp;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, predict its outcome, and leave the response pending.
    task automatic do_req(input logic st, input size_e sz, input logic sg,
                          input logic [63:0] base, input logic [8:0] off,
                          input logic [63:0] wd);
        logic [63:0] ea, mask, exp_data, exp_wd, seen_addr, seen_wd;
        logic [1:0]  code, seen_sz;
        longint      off_l;
        int nb, lat, lat_seen, nwr, nrd;
        logic got;

        off_l = longint'($signed(off));
        ea    = base + 64'(off_l);
        nb    = tb_nbytes(sz);
        mask  = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        if (ea % 64'(nb) != 64'd0)                              code = 2'b01;
        else if (ea >= 64'(MEM_BYTES) || ea + 64'(nb) > 64'(MEM_BYTES)) code = 2'b10;
        else                                                    code = 2'b00;
        exp_wd   = wd & mask;
        exp_data = 64'd0;
        if (code == 2'b00 && !st) begin
            for (int i = 0; i < nb; i++)
                exp_data = exp_data | (64'(ref_mem[int'(ea) + i]) << (8 * i));
            if (sg && nb < 8 && exp_data[8*nb-1]) exp_data = exp_data | ~mask;
        end
        lat = (code != 2'b00) ? 1 : (st ? 2 : 3);

        @(negedge clk);
        bus.req_is_store = st;
        bus.req_size     = sz;
        bus.req_signed   = sg;
        bus.req_base     = base;
        bus.req_offset   = off;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        check("req_ready_idle", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;

        got = 1'b0; lat_seen = 0; nwr = 0; nrd = 0;
        seen_addr = '0; seen_wd = '0; seen_sz = 2'b00;
        for (int k = 1; k <= 10 && !got; k++) begin
            @(negedge clk);
            if (bus.mem_write) begin nwr++; seen_addr = bus.mem_address; seen_wd = bus.mem_wdata; seen_sz = bus.mem_size_select; end
            if (bus.mem_read)  begin nrd++; seen_addr = bus.mem_address; seen_sz = bus.mem_size_select; end
            if (bus.resp_valid) begin got = 1'b1; lat_seen = k; end
        end
        check("latency",    64'(lat_seen), 64'(lat));
        check("resp_data",  bus.resp_data, exp_data);
        check("resp_fault", 64'(bus.resp_fault), 64'(code != 2'b00));
        check("fault_code", 64'(bus.resp_fault_code), 64'(code));
        check("write_cnt",  64'(nwr), 64'((code == 2'b00 && st) ? 1 : 0));
        check("read_cnt",   64'(nrd), 64'((code == 2'b00 && !st) ? 1 : 0));
        if (code == 2'b00) begin
            check("mem_addr", seen_addr, ea);
            check("mem_size", 64'(seen_sz), 64'(sz));
            if (st) begin
                check("mem_wdata", seen_wd, exp_wd);
                for (int i = 0; i < nb; i++) ref_mem[int'(ea) + i] = wd[8*i +: 8];
            end
        end
        last_resp = bus.resp_data;
        last_exp  = exp_data;
    endtask

    // Consume the pending response and confirm the return to idle.
    task automatic release_resp();
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        @(negedge clk);
        check("idle_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("idle_req_ready",  64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        logic [8:0] off_r;
        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_size     = WORD;
        bus.req_signed   = 1'b0;
        bus.req_base     = '0;
        bus.req_offset   = '0;
        bus.req_wdata    = '0;
        bus.resp_ready   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready",  64'(bus.req_ready), 64'd1);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_mem_write",  64'(bus.mem_write), 64'd0);
        check("rst_mem_read",   64'(bus.mem_read), 64'd0);
        check("rst_mem_addr",   bus.mem_address, 64'd0);
        check("rst_resp_data",  bus.resp_data, 64'd0);
        reset = 1'b0;

        // Directed sequence.
        do_req(1'b1, DOUBLE, 1'b0, 64'h10, 9'h000, 64'h8877665544332211); release_resp();
        do_req(1'b0, BYTE,   1'b1, 64'h10, 9'h007, 64'h0);
        check("ld_b_s_lit", last_resp, 64'hFFFFFFFFFFFFFF88); release_resp();
        do_req(1'b0, HALF,   1'b0, 64'h16, 9'h000, 64'h0);
        check("ld_h_u_lit", last_resp, 64'h0000000000008877); release_resp();
        do_req(1'b0, WORD,   1'b1, 64'h14, 9'h000, 64'h0);
        check("ld_w_s_lit", last_resp, 64'hFFFFFFFF88776655); release_resp();
        do_req(1'b0, DOUBLE, 1'b0, 64'h20, 9'h1F8, 64'h0); release_resp();
        do_req(1'b0, WORD,   1'b0, 64'h12, 9'h000, 64'h0); release_resp();
        do_req(1'b0, DOUBLE, 1'b0, 64'h58, 9'h000, 64'h0); release_resp();
        do_req(1'b0, BYTE,   1'b0, 64'hFFFFFFFFFFFFFFFE, 9'h000, 64'h0); release_resp();

        // Backpressure: response holds while a new request is ignored.
        do_req(1'b0, WORD, 1'b0, 64'h10, 9'h004, 64'h0);
        @(negedge clk);
        bus.req_is_store = 1'b1; bus.req_size = DOUBLE; bus.req_base = 64'h10;
        bus.req_offset = 9'h000; bus.req_wdata = 64'hDEADBEEFCAFEF00D; bus.req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
            check("bp_resp_data",  bus.resp_data, last_exp);
            check("bp_fault",      64'(bus.resp_fault), 64'd0);
            check("bp_req_ready",  64'(bus.req_ready), 64'd0);
            check("bp_mem_write",  64'(bus.mem_write), 64'd0);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        release_resp();
        do_req(1'b0, DOUBLE, 1'b0, 64'h10, 9'h000, 64'h0);
        check("bp_no_store", last_resp, 64'h8877665544332211); release_resp();

        // Reset during the ACCESS cycle of a store.
        @(negedge clk);
        bus.req_is_store = 1'b1; bus.req_size = DOUBLE; bus.req_base = 64'h30;
        bus.req_offset = 9'h000; bus.req_wdata = 64'h0123456789ABCDEF; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("acc_mem_write", 64'(bus.mem_write), 64'd1);
        reset = 1'b1;
        #1 check("rst_gates_write", 64'(bus.mem_write), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready",  64'(bus.req_ready), 64'd1);
        check("post_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        do_req(1'b0, DOUBLE, 1'b0, 64'h30, 9'h000, 64'h0);
        check("rst_mem_unchanged", last_resp, 64'h0); release_resp();

        // Randomised requests against the reference model.
        for (int n = 0; n < 60; n++) begin
            off_r = 9'($urandom_range(0, 24)) - 9'd8;
            do_req(1'($urandom_range(0, 1)), size_e'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 64'($urandom_range(0, 96)), off_r,
                   {$urandom, $urandom});
            release_resp();
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
